// File: rtl/biriscv_tcm_pkg.sv
// Shared widths and defaults for the biriscv tightly-coupled memory.
package biriscv_tcm_pkg;
  localparam int unsigned TCM_TAG_W = 11;
  localparam int unsigned TCM_DATA_W = 32;
  localparam int unsigned TCM_FETCH_W = 64;
  localparam int unsigned TCM_MEM_BYTES_DEFAULT = 131072;
endpackage

// File: rtl/biriscv_tcm_ram.sv
// True dual-port read-first RAM, 64-bit wide: port A read-only, port B
// read/write with per-byte enables.
module biriscv_tcm_ram
  import biriscv_tcm_pkg::*;
#(
  parameter int unsigned DEPTH_W = 14
) (
  input  logic                   clk,
  input  logic [DEPTH_W-1:0]     addr_a,
  output logic [TCM_FETCH_W-1:0] q_a,
  input  logic [DEPTH_W-1:0]     addr_b,
  input  logic [7:0]             be_b,
  input  logic [TCM_FETCH_W-1:0] wdata_b,
  output logic [TCM_FETCH_W-1:0] q_b
);
  localparam int unsigned WORDS = 1 << DEPTH_W;

  logic [TCM_FETCH_W-1:0] mem [0:WORDS-1];

  always_ff @(posedge clk) begin
    q_a <= mem[addr_a];
  end

  // Plain always so the optional simulation backdoor may also poke mem.
  // Both read ports see the pre-write contents of a colliding write.
  always @(posedge clk) begin
    q_b <= mem[addr_b];
    for (int i = 0; i < 8; i++) begin
      if (be_b[i]) mem[addr_b][8*i +: 8] <= wdata_b[8*i +: 8];
    end
  end
endmodule

// File: rtl/biriscv_tcm.sv
// Tightly-coupled memory: 64-bit fetch port and 32-bit tagged data port over
// one shared RAM, fixed one-cycle latency. TCM_BACKDOOR_EN adds sim byte tasks.
module biriscv_tcm
  import biriscv_tcm_pkg::*;
#(
  parameter int unsigned MEM_BYTES = TCM_MEM_BYTES_DEFAULT
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   mem_i_rd_i,
  input  logic                   mem_i_flush_i,
  input  logic                   mem_i_invalidate_i,
  input  logic [31:0]            mem_i_pc_i,
  output logic                   mem_i_accept_o,
  output logic                   mem_i_valid_o,
  output logic                   mem_i_error_o,
  output logic [TCM_FETCH_W-1:0] mem_i_inst_o,
  input  logic [31:0]            mem_d_addr_i,
  input  logic [TCM_DATA_W-1:0]  mem_d_data_wr_i,
  input  logic                   mem_d_rd_i,
  input  logic [3:0]             mem_d_wr_i,
  input  logic                   mem_d_cacheable_i,
  input  logic [TCM_TAG_W-1:0]   mem_d_req_tag_i,
  input  logic                   mem_d_invalidate_i,
  input  logic                   mem_d_writeback_i,
  input  logic                   mem_d_flush_i,
  output logic [TCM_DATA_W-1:0]  mem_d_data_rd_o,
  output logic                   mem_d_accept_o,
  output logic                   mem_d_ack_o,
  output logic                   mem_d_error_o,
  output logic [TCM_TAG_W-1:0]   mem_d_resp_tag_o
);
  localparam int unsigned AW = $clog2(MEM_BYTES);

  // Handshake: accept is always 1, so a request is taken in any cycle its
  // strobe is high outside reset; valid/ack pulse for exactly one cycle,
  // one clock later, and there is no ready/stall path back to the core.
  logic                   d_req;
  logic [7:0]             be_b;
  logic [TCM_FETCH_W-1:0] q_a;
  logic [TCM_FETCH_W-1:0] q_b;
  logic                   i_valid_q;
  logic                   d_ack_q;
  logic                   d_rd_q;
  logic                   d_lane_q;
  logic [TCM_TAG_W-1:0]   d_tag_q;
  logic                   unused_ok;

  assign d_req = mem_d_rd_i | (|mem_d_wr_i) | mem_d_flush_i |
                 mem_d_invalidate_i | mem_d_writeback_i;

  // Writes are suppressed during reset so dropped requests leave RAM intact.
  assign be_b = rst_i ? 8'h00 :
                (mem_d_addr_i[2] ? {mem_d_wr_i, 4'h0} : {4'h0, mem_d_wr_i});

  biriscv_tcm_ram #(.DEPTH_W(AW - 3)) u_ram (
    .clk     (clk_i),
    .addr_a  (mem_i_pc_i[AW-1:3]),
    .q_a     (q_a),
    .addr_b  (mem_d_addr_i[AW-1:3]),
    .be_b    (be_b),
    .wdata_b ({mem_d_data_wr_i, mem_d_data_wr_i}),
    .q_b     (q_b)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      i_valid_q <= 1'b0;
      d_ack_q   <= 1'b0;
      d_rd_q    <= 1'b0;
      d_lane_q  <= 1'b0;
      d_tag_q   <= '0;
    end else begin
      i_valid_q <= mem_i_rd_i;
      d_ack_q   <= d_req;
      d_rd_q    <= mem_d_rd_i;
      d_lane_q  <= mem_d_addr_i[2];
      d_tag_q   <= d_req ? mem_d_req_tag_i : '0;
    end
  end

  // RAM outputs change every cycle; gate them so idle outputs read as zero.
  assign mem_i_valid_o    = i_valid_q;
  assign mem_i_inst_o     = i_valid_q ? q_a : '0;
  assign mem_d_ack_o      = d_ack_q;
  assign mem_d_resp_tag_o = d_tag_q;
  assign mem_d_data_rd_o  = (d_ack_q && d_rd_q) ?
                            (d_lane_q ? q_b[63:32] : q_b[31:0]) : '0;

  assign mem_i_accept_o = 1'b1;
  assign mem_i_error_o  = 1'b0;
  assign mem_d_accept_o = 1'b1;
  assign mem_d_error_o  = 1'b0;

  assign unused_ok = ^{mem_i_flush_i, mem_i_invalidate_i, mem_d_cacheable_i,
                       mem_i_pc_i[2:0], mem_i_pc_i[31:AW],
                       mem_d_addr_i[1:0], mem_d_addr_i[31:AW]};

`ifdef TCM_BACKDOOR_EN
  task write(input logic [31:0] addr, input logic [7:0] data8);
    u_ram.mem[addr[AW-1:3]][8*addr[2:0] +: 8] = data8;
  endtask

  function automatic logic [7:0] read(input logic [31:0] addr);
    return u_ram.mem[addr[AW-1:3]][8*addr[2:0] +: 8];
  endfunction
`endif
endmodule

// File: tb/tb_biriscv_tcm.sv
// Self-checking bench for biriscv_tcm: byte-level memory model plus directed
// literal checks and a randomized traffic phase.
module tb_biriscv_tcm;
  localparam int unsigned MB = 131072;
  localparam int unsigned NDW = 72;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_rd, i_flush, i_inv;
  logic [31:0] i_pc;
  logic        i_accept, i_valid, i_error;
  logic [63:0] i_inst;
  logic [31:0] d_addr, d_wdata;
  logic        d_rd, d_cach, d_inv, d_wb, d_flush;
  logic [3:0]  d_wr;
  logic [10:0] d_tag;
  logic [31:0] d_rdata;
  logic        d_accept, d_ack, d_error;
  logic [10:0] d_rtag;

  int tests = 0;
  int fails = 0;
  bit chk_en = 0;

  logic [7:0]  mb [0:MB-1];
  logic        e_valid, e_ack;
  logic [63:0] e_inst;
  logic [31:0] e_data;
  logic [10:0] e_tag;

  always #5 clk = ~clk;

  biriscv_tcm dut (
    .clk_i(clk), .rst_i(rst),
    .mem_i_rd_i(i_rd), .mem_i_flush_i(i_flush), .mem_i_invalidate_i(i_inv),
    .mem_i_pc_i(i_pc), .mem_i_accept_o(i_accept), .mem_i_valid_o(i_valid),
    .mem_i_error_o(i_error), .mem_i_inst_o(i_inst),
    .mem_d_addr_i(d_addr), .mem_d_data_wr_i(d_wdata), .mem_d_rd_i(d_rd),
    .mem_d_wr_i(d_wr), .mem_d_cacheable_i(d_cach), .mem_d_req_tag_i(d_tag),
    .mem_d_invalidate_i(d_inv), .mem_d_writeback_i(d_wb),
    .mem_d_flush_i(d_flush), .mem_d_data_rd_o(d_rdata),
    .mem_d_accept_o(d_accept), .mem_d_ack_o(d_ack), .mem_d_error_o(d_error),
    .mem_d_resp_tag_o(d_rtag)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] model_dw(input logic [31:0] a);
    int unsigned b;
    logic [63:0] r;
    b = (a % MB) & ~32'd7;
    for (int k = 0; k < 8; k++) r[8*k +: 8] = mb[b + k];
    return r;
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] a);
    logic [63:0] dw;
    dw = model_dw(a);
    return a[2] ? dw[63:32] : dw[31:0];
  endfunction

  // Reference model: what the outputs must show after this rising edge.
  always @(posedge clk) begin
    logic req;
    int unsigned b;
    if (rst) begin
      e_valid = 0; e_inst = 0; e_ack = 0; e_data = 0; e_tag = 0;
    end else begin
      req = d_rd | (|d_wr) | d_flush | d_inv | d_wb;
      e_valid = i_rd;
      e_inst  = i_rd ? model_dw(i_pc) : 64'd0;
      e_ack   = req;
      e_tag   = req ? d_tag : 11'd0;
      e_data  = d_rd ? model_word(d_addr) : 32'd0;
      b = (d_addr % MB) & ~32'd3;
      for (int k = 0; k < 4; k++) if (d_wr[k]) mb[b + k] = d_wdata[8*k +: 8];
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("i_valid", {63'd0, i_valid}, {63'd0, e_valid});
      chk("i_inst", i_inst, e_inst);
      chk("d_ack", {63'd0, d_ack}, {63'd0, e_ack});
      chk("d_data", {32'd0, d_rdata}, {32'd0, e_data});
      chk("d_tag", {53'd0, d_rtag}, {53'd0, e_tag});
      chk("const", {60'd0, i_accept, i_error, d_accept, d_error}, 64'hA);
    end
  end

  task automatic clr();
    i_rd = 0; i_flush = 0; i_inv = 0; i_pc = 0;
    d_addr = 0; d_wdata = 0; d_rd = 0; d_wr = 0; d_cach = 0;
    d_tag = 0; d_inv = 0; d_wb = 0; d_flush = 0;
  endtask

  task automatic step();
    @(negedge clk);
    clr();
  endtask

  task automatic dwrite(input logic [31:0] a, input logic [31:0] v);
    d_addr = a; d_wdata = v; d_wr = 4'hF; d_tag = 11'(a);
    step();
  endtask

  initial begin
    logic [31:0] m;
    clr();
    rst = 1;
    repeat (3) @(negedge clk);
    chk("rst_valid", {63'd0, i_valid}, 64'd0);
    chk("rst_inst", i_inst, 64'd0);
    chk("rst_ack", {63'd0, d_ack}, 64'd0);
    chk("rst_data", {32'd0, d_rdata}, 64'd0);
    chk("rst_tag", {53'd0, d_rtag}, 64'd0);
    chk("rst_const", {60'd0, i_accept, i_error, d_accept, d_error}, 64'hA);
    chk_en = 1;
    rst = 0;

    for (int i = 0; i < 2 * NDW; i++) dwrite(32'h8000_0000 + 32'(i * 4), $urandom);

`ifdef TCM_BACKDOOR_EN
    begin
      logic [7:0] prog [0:7];
      prog = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
      for (int i = 0; i < 8; i++) begin
        dut.write(32'(i), prog[i]);
        mb[i] = prog[i];
      end
      chk("bd_read", {56'd0, dut.read(32'd4)}, 64'h93);
    end
`else
    dwrite(32'h8000_0000, 32'h0000_0013);
    dwrite(32'h8000_0004, 32'h0010_0093);
`endif
    i_rd = 1; i_pc = 32'h8000_0000;
    step();
    chk("fetch_prog", i_inst, 64'h0010_0093_0000_0013);

    dwrite(32'h8000_0104, 32'h0);
    dwrite(32'h8000_0100, 32'h1122_3344);
    d_addr = 32'h8000_0104; d_wr = 4'b0011; d_wdata = 32'hAABB_CCDD; d_tag = 11'h155;
    step();
    chk("wr_tag", {53'd0, d_rtag}, 64'h155);
    chk("wr_data0", {32'd0, d_rdata}, 64'd0);
    d_addr = 32'h8000_0104; d_rd = 1; d_tag = 11'h2AA;
    step();
    chk("rd_tag", {53'd0, d_rtag}, 64'h2AA);
    chk("rd_data", {32'd0, d_rdata}, 64'h0000_CCDD);

    d_addr = 32'h8000_0100; d_rd = 1; d_tag = 11'h1;
    step();
    chk("b2b_lo", {31'd0, d_ack, d_rdata}, 64'h1_1122_3344);
    d_addr = 32'h8000_0104; d_rd = 1; d_tag = 11'h2;
    step();
    chk("b2b_hi", {31'd0, d_ack, d_rdata}, 64'h1_0000_CCDD);

    dwrite(32'h8000_0200, 32'h89AB_CDEF);
    dwrite(32'h8000_0204, 32'h0123_4567);
    i_rd = 1; i_pc = 32'h8000_0200;
    d_addr = 32'h8000_0200; d_wr = 4'hF; d_wdata = 32'hFFFF_FFFF;
    step();
    chk("coll_old", i_inst, 64'h0123_4567_89AB_CDEF);
    i_rd = 1; i_pc = 32'h8000_0200;
    step();
    chk("coll_new", i_inst, 64'h0123_4567_FFFF_FFFF);

    d_addr = 32'h8000_0104; d_flush = 1; d_tag = 11'h7FF; d_wdata = 32'hDEAD_BEEF;
    step();
    chk("flush", {20'd0, d_ack, d_rtag, d_rdata}, {20'd0, 1'b1, 11'h7FF, 32'd0});
    d_addr = 32'h8000_0104; d_rd = 1;
    step();
    chk("flush_keep", {32'd0, d_rdata}, 64'h0000_CCDD);

    for (int n = 0; n < 400; n++) begin
      i_rd = 1'($urandom);
      i_flush = 1'($urandom_range(0, 7) == 0);
      i_inv = 1'($urandom_range(0, 7) == 0);
      i_pc = {$urandom_range(0, 32767), 17'd0} | 32'($urandom_range(0, NDW - 1) * 8)
             | 32'($urandom_range(0, 7));
      d_addr = {$urandom_range(0, 32767), 17'd0} | 32'($urandom_range(0, NDW - 1) * 8)
               | 32'($urandom_range(0, 7));
      d_wdata = $urandom;
      d_rd = 1'($urandom);
      d_wr = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      d_cach = 1'($urandom);
      d_tag = 11'($urandom);
      d_flush = 1'($urandom_range(0, 9) == 0);
      d_inv = 1'($urandom_range(0, 9) == 0);
      d_wb = 1'($urandom_range(0, 9) == 0);
      if (n == 200) begin
        m = model_word(32'h8000_0028);
        rst = 1; i_rd = 1; d_rd = 1; i_pc = 32'h8000_0028;
        d_addr = 32'h8000_0028; d_wr = 4'hF; d_wdata = ~m;
        step();
        chk("midrst", {62'd0, i_valid, d_ack}, 64'd0);
        rst = 0;
        d_addr = 32'h8000_0028; d_rd = 1;
        step();
        chk("midrst_keep", {32'd0, d_rdata}, {32'd0, m});
      end else begin
        step();
      end
    end

    step();
    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    fails++;
    $display("FAIL watchdog timeout");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end
endmodule
